// File: rtl/count_seg_display.sv
// count_seg_display: scans a 4-bit count onto a 4-digit, common-anode,
// time-multiplexed seven-segment display.
//   digit 0 = decimal ones, digit 1 = decimal tens (leading zero blanked),
//   digit 2 = hex value,    digit 3 = always blank.
// The count is captured once per scan frame, so every digit within a frame
// shows the same value. Anodes and cathodes are active-low and registered.
module count_seg_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;
  localparam logic [3:0]       AN_OFF    = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble.
  function automatic logic [6:0] hex_pattern(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      4'hF:    p = 7'b0001110;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  // Active-low anode code: only the selected digit's bit is cleared.
  function automatic logic [3:0] anode_code(input logic [1:0] s);
    logic [3:0] a;
    case (s)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      2'd3:    a = 4'b0111;
      default: a = AN_OFF;
    endcase
    return a;
  endfunction

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick_s;
  logic             tens_s;
  logic [3:0]       ones_s;
  logic [6:0]       digit_seg_s;

  // Refresh divider, digit selector and once-per-frame count snapshot.
  always_comb begin
    tick_s    = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q + DIV_ONE;
    sel_d     = sel_q;
    snap_d    = snap_q;
    if (tick_s) begin
      div_cnt_d = '0;
      sel_d     = sel_q + 2'd1;
      if (sel_q == 2'd3) begin
        snap_d = value;
      end else begin
        snap_d = snap_q;
      end
    end else begin
      sel_d  = sel_q;
      snap_d = snap_q;
    end
  end

  // Split the snapshot into decimal digits and pick the lit digit's pattern.
  always_comb begin
    tens_s      = (snap_q >= 4'd10);
    ones_s      = snap_q;
    digit_seg_s = SEG_BLANK;
    if (tens_s) begin
      ones_s = snap_q - 4'd10;
    end else begin
      ones_s = snap_q;
    end
    case (sel_q)
      2'd0: digit_seg_s = hex_pattern(ones_s);
      2'd1: begin
        if (tens_s) begin
          digit_seg_s = hex_pattern(4'd1);
        end else begin
          digit_seg_s = SEG_BLANK;
        end
      end
      2'd2:    digit_seg_s = hex_pattern(snap_q);
      2'd3:    digit_seg_s = SEG_BLANK;
      default: digit_seg_s = SEG_BLANK;
    endcase
  end

  // Output next-state: blank forces everything dark without stopping the scan.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = anode_code(sel_q);
      seg_d = digit_seg_s;
    end
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sel_q     <= 2'd0;
      snap_q    <= 4'd0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      div_cnt_q <= div_cnt_d;
      sel_q     <= sel_d;
      snap_q    <= snap_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_count_seg_display.sv
// Bench for count_seg_display with a short refresh period. A cycle-count
// reference model (digit = frame position, decimal split by / and %) runs
// alongside the scenario tasks, which also check literal frame contents.
module tb_count_seg_display;

  localparam int R = 4;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] PAT [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] value = 4'd0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state: k = edges since reset, m_snap = displayed count
  int k = 0;
  int m_snap = 0;
  logic [3:0] exp_an = 4'b1111;
  logic [6:0] exp_seg = 7'b1111111;

  count_seg_display #(.REFRESH_DIV(R), .DIV_W(4)) dut (
    .clk(clk), .rst(rst), .value(value), .blank(blank), .an(an), .seg(seg));

  always #5 clk = ~clk;

  function automatic logic [6:0] model_digit(input int pos, input int v);
    case (pos)
      0:       return PAT[v % 10];
      1:       return (v / 10 != 0) ? PAT[v / 10] : BL;
      2:       return PAT[v];
      default: return BL;
    endcase
  endfunction

  // reference model: digit position = (edges since reset / R) mod 4
  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_snap = 0; exp_an = 4'b1111; exp_seg = BL;
    end else begin
      if (blank) begin
        exp_an = 4'b1111; exp_seg = BL;
      end else begin
        exp_an = ~(4'b0001 << ((k / R) % 4));
        exp_seg = model_digit((k / R) % 4, m_snap);
      end
      if (k % (4 * R) == 4 * R - 1) m_snap = int'(value);
      k = k + 1;
    end
  end

  task automatic wait_phase(input int s, input int d, input string tag);
    int n = 0;
    while (!(((k / R) % 4) == s && (k % R) == d) && n < 200) begin
      @(negedge clk); n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("FAIL %s: phase sel=%0d div=%0d not reached in %0d cycles", tag, s, d, n);
    end
  endtask

  task automatic wait_frame(input int v, input string tag);
    int n = 0;
    while (!((k % (4 * R)) == 0 && m_snap == v) && n < 200) begin
      @(negedge clk); n++;
    end
    tests_run++;
    if (n >= 200) begin
      tests_failed++;
      $display("FAIL %s: frame showing %0d not reached in %0d cycles", tag, v, n);
    end
  endtask

  task automatic test_reset();
    logic [6:0] lit [4] = '{7'b1000000, BL, 7'b1000000, BL};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); tests_run++;
      if (an !== 4'b1111 || seg !== BL) begin
        tests_failed++;
        $display("FAIL reset_hold: an=%b seg=%b want an=1111 seg=1111111", an, seg);
      end
    end
    rst = 1'b0;
    value = 4'd11;
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== ~(4'b0001 << (i / R)) || seg !== lit[i / R]) begin
        tests_failed++;
        $display("FAIL reset_release[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, ~(4'b0001 << (i / R)), lit[i / R]);
      end
    end
  endtask

  task automatic test_two_digit();
    logic [6:0] lit [4] = '{7'b0110000, 7'b1111001, 7'b0100001, BL};
    value = 4'd13;
    wait_frame(13, "two_digit_wait");
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== ~(4'b0001 << (i / R)) || seg !== lit[i / R]) begin
        tests_failed++;
        $display("FAIL two_digit[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, ~(4'b0001 << (i / R)), lit[i / R]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] lit [4] = '{7'b1111000, BL, 7'b1111000, BL};
    value = 4'd7;
    wait_frame(7, "lead_zero_wait");
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== ~(4'b0001 << (i / R)) || seg !== lit[i / R]) begin
        tests_failed++;
        $display("FAIL leading_zero[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, ~(4'b0001 << (i / R)), lit[i / R]);
      end
    end
  endtask

  task automatic test_mid_change();
    logic [6:0] lit13 [4] = '{7'b0110000, 7'b1111001, 7'b0100001, BL};
    logic [6:0] lit5 [4]  = '{7'b0010010, BL, 7'b0010010, BL};
    value = 4'd13;
    wait_frame(13, "mid_change_frame");
    wait_phase(1, 0, "mid_change_sel1");
    value = 4'd5;
    for (int i = 0; i < 3 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== ~(4'b0001 << (1 + i / R)) || seg !== lit13[1 + i / R]) begin
        tests_failed++;
        $display("FAIL mid_change_old[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, ~(4'b0001 << (1 + i / R)), lit13[1 + i / R]);
      end
    end
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== ~(4'b0001 << (i / R)) || seg !== lit5[i / R]) begin
        tests_failed++;
        $display("FAIL mid_change_new[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, ~(4'b0001 << (i / R)), lit5[i / R]);
      end
    end
  endtask

  task automatic test_blank();
    value = 4'd12;
    wait_phase(1, 0, "blank_sel1");
    blank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); tests_run++;
      if (an !== 4'b1111 || seg !== BL) begin
        tests_failed++;
        $display("FAIL blank_on[%0d]: an=%b seg=%b want an=1111 seg=1111111", i, an, seg);
      end
    end
    blank = 1'b0;
    @(negedge clk); tests_run++;
    if (an !== 4'b1011) begin
      tests_failed++;
      $display("FAIL blank_resume: an=%b want 1011", an);
    end
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== exp_an || seg !== exp_seg) begin
        tests_failed++;
        $display("FAIL blank_after[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] lit [4] = '{7'b1000000, BL, 7'b1000000, BL};
    value = 4'd9;
    wait_frame(9, "reset_mid_frame");
    wait_phase(2, 2, "reset_mid_phase");
    rst = 1'b1;
    @(negedge clk); tests_run++;
    if (an !== 4'b1111 || seg !== BL) begin
      tests_failed++;
      $display("FAIL reset_mid: an=%b seg=%b want an=1111 seg=1111111", an, seg);
    end
    rst = 1'b0;
    for (int i = 0; i < 4 * R; i++) begin
      @(negedge clk); tests_run++;
      if (an !== ~(4'b0001 << (i / R)) || seg !== lit[i / R]) begin
        tests_failed++;
        $display("FAIL reset_mid_restart[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, ~(4'b0001 << (i / R)), lit[i / R]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); tests_run++;
      if (an !== exp_an || seg !== exp_seg) begin
        tests_failed++;
        $display("FAIL random[%0d]: an=%b seg=%b want an=%b seg=%b",
                 i, an, seg, exp_an, exp_seg);
      end
      if ($urandom_range(0, 5) == 0) value = 4'($urandom_range(0, 15));
      blank = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 79) == 0);
    end
    rst = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_digit();
    test_leading_zero();
    test_mid_change();
    test_blank();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
